dcache_access_controller: RTL and testbench
===========================================

Name: dcache_access_controller

Overview:
- Sequences every data-cache access held in the EX/MEM pipeline register: captures the request, drives the d-cache port, and stalls the pipeline until the cache answers.
- Pulses unlock back to the EX/MEM register so it accepts new instructions again.
- Returns load data, byte-extracted, for writeback.
- Sits between the EX/MEM register, the data cache and the writeback mux.

Parameters:
WORD_WIDTH, 32, data/address width
REGISTER_INDEX_WIDTH, 5, destination register index width
TIMEOUT_CYCLES, 64, max cycles waiting for cache_ready_in before abort
TIMEOUT_WIDTH, 7, counter width; must satisfy 2^TIMEOUT_WIDTH > TIMEOUT_CYCLES

Ports:
clk  in  1  single clock; all state updates on posedge
rst_n  in  1  asynchronous, active-low reset
req_valid_in  in  1  EX/MEM holds an active cache access (active & d_cache_access)
req_op_in  in  1  0 = load, 1 = store
req_byte_in  in  1  byte operation
req_addr_in  in  WORD_WIDTH  effective address (ALU result)
req_wdata_in  in  WORD_WIDTH  store data (second register)
req_dest_in  in  REGISTER_INDEX_WIDTH  load destination register
flush_in  in  1  pipeline flush; suppresses writeback of the current or incoming access
cache_ready_in  in  1  cache completed the access this cycle
cache_rdata_in  in  WORD_WIDTH  cache read data, valid with cache_ready_in
cache_req_out  out  1  request to d-cache, held until ready
cache_op_out  out  1  captured op
cache_byte_out  out  1  captured byte flag
cache_addr_out  out  WORD_WIDTH  captured address
cache_wdata_out  out  WORD_WIDTH  captured store data
stall_out  out  1  pipeline stall
unlock_out  out  1  one-cycle pulse releasing the EX/MEM lock
wb_valid_out  out  1  one-cycle pulse; load data valid
wb_dest_out  out  REGISTER_INDEX_WIDTH  load destination
wb_data_out  out  WORD_WIDTH  load result
timeout_out  out  1  sticky error flag
busy_out  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n = 0): state IDLE; all outputs 0; timeout counter 0; timeout_out cleared; suppress flag cleared. Applies mid-operation: any outstanding request is dropped and no unlock or writeback is produced.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On posedge with req_valid_in = 1 and flush_in = 0: capture op, byte, addr, wdata and dest; clear counter; go to WAIT.
  - req_valid_in together with flush_in is ignored; the FSM stays in IDLE.
- WAIT:
  - cache_req_out = 1 and cache_* outputs hold the captured values for the whole state.
  - The counter increments each cycle.
  - On posedge with cache_ready_in = 1: latch cache_rdata_in and go to DONE.
  - If ready has not arrived and the counter reaches TIMEOUT_CYCLES-1: set timeout_out, mark the access aborted, go to DONE.
  - If cache_ready_in arrives in the same cycle as the timeout, ready wins: the access is not aborted and timeout_out is not set.
  - flush_in in WAIT does not abort the cache access (stores must complete). It sets a suppress flag that blocks writeback.
- DONE (exactly one cycle):
  - cache_req_out = 0; unlock_out = 1.
  - wb_valid_out = 1 only for a load that is neither aborted nor suppressed.
  - Always returns to IDLE. req_valid_in is ignored in DONE.
- stall_out = 1 in WAIT and DONE, 0 in IDLE (decoded from the state register).
- Latency:
  - Accept at edge N; cache_req_out high from N.
  - Ready sampled at edge N+1 at the earliest; DONE during N+1..N+2; IDLE after N+2.
  - Minimum 3-cycle occupancy; back-to-back requests are accepted every 3 cycles.
- Load data (wb_data_out):
  - Word load: the latched cache_rdata_in.
  - Byte load: zero-extended byte cache_rdata_in[8*addr[1:0] +: 8].
- Store: cache_wdata_out = captured wdata unmodified; the cache uses cache_byte_out and addr[1:0] for the lane.
- wb_dest_out and wb_data_out hold their value after DONE until the next load completes.
- timeout_out stays set until reset.

Test Plan:
- Word load, addr 0x10, dest 5; ready 2 cycles after request with rdata 0xDEADBEEF -> stall high 3 cycles; single unlock pulse; wb_valid pulse with dest 5, data 0xDEADBEEF.
- Byte load, addr 0x13; ready with rdata 0xAABBCCDD -> wb_data 0x000000AA.
- Store, addr 0x20, wdata 0x12345678, byte 0; ready next cycle -> cache_req held with captured values until ready; unlock pulse; no wb_valid.
- Load with flush_in asserted in WAIT -> cache_req stays until ready; unlock pulses; wb_valid stays 0.
- Timeout: no ready for 64 cycles -> timeout_out = 1 at cycle 64; unlock pulse; no wb_valid. With ready asserted exactly in that cycle -> normal completion, timeout_out = 0.
- rst_n low during WAIT -> all outputs 0 immediately; no unlock after release; new request accepted normally.

Source files
------------

// File: rtl/dcache_access_controller.sv
// dcache_access_controller
// Sequences one data-cache access at a time out of the EX/MEM register:
// captures the request, holds the d-cache port until the cache answers,
// stalls the pipeline meanwhile, pulses unlock and returns load data.
// Every output is decoded from registered state, so none of them depends
// combinationally on an input.
module dcache_access_controller #(
   parameter int WORD_WIDTH           = 32,
   parameter int REGISTER_INDEX_WIDTH = 5,
   parameter int TIMEOUT_CYCLES       = 64,
   parameter int TIMEOUT_WIDTH        = 7
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            req_valid_in,
   input  logic                            req_op_in,
   input  logic                            req_byte_in,
   input  logic [WORD_WIDTH-1:0]           req_addr_in,
   input  logic [WORD_WIDTH-1:0]           req_wdata_in,
   input  logic [REGISTER_INDEX_WIDTH-1:0] req_dest_in,
   input  logic                            flush_in,
   input  logic                            cache_ready_in,
   input  logic [WORD_WIDTH-1:0]           cache_rdata_in,
   output logic                            cache_req_out,
   output logic                            cache_op_out,
   output logic                            cache_byte_out,
   output logic [WORD_WIDTH-1:0]           cache_addr_out,
   output logic [WORD_WIDTH-1:0]           cache_wdata_out,
   output logic                            stall_out,
   output logic                            unlock_out,
   output logic                            wb_valid_out,
   output logic [REGISTER_INDEX_WIDTH-1:0] wb_dest_out,
   output logic [WORD_WIDTH-1:0]           wb_data_out,
   output logic                            timeout_out,
   output logic                            busy_out
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [1:0]                      state;
   logic                            op_q;
   logic                            byte_q;
   logic [WORD_WIDTH-1:0]           addr_q;
   logic [WORD_WIDTH-1:0]           wdata_q;
   logic [REGISTER_INDEX_WIDTH-1:0] dest_q;
   logic [TIMEOUT_WIDTH-1:0]        cnt;
   logic                            aborted;
   logic                            suppress;
   logic                            timeout_q;
   logic [REGISTER_INDEX_WIDTH-1:0] wb_dest_q;
   logic [WORD_WIDTH-1:0]           wb_data_q;
   logic [7:0]                      rbyte;
   logic                            accept;
   logic                            expire;
   logic                            wb_take;

   assign accept  = (state == IDLE) && req_valid_in && !flush_in;
   // ready on the last counted cycle beats the timeout
   assign expire  = (state == WAIT) && !cache_ready_in && (cnt == CNT_LAST);
   // a flush on the completing edge still blocks this load's writeback
   assign wb_take = (state == WAIT) && cache_ready_in && !op_q && !suppress && !flush_in;

   // byte lane of the returning word selected by the captured address
   always_comb begin
      rbyte = cache_rdata_in[7:0];
      case (addr_q[1:0])
         2'd1:    rbyte = cache_rdata_in[15:8];
         2'd2:    rbyte = cache_rdata_in[23:16];
         2'd3:    rbyte = cache_rdata_in[31:24];
         default: rbyte = cache_rdata_in[7:0];
      endcase
   end

   // state sequencing: IDLE -> WAIT -> DONE (one cycle) -> IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state <= WAIT;
            WAIT:    if (cache_ready_in || expire) state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // request capture; values stay on the cache port until the next accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= 1'b0;
         byte_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         dest_q  <= '0;
      end else if (accept) begin
         op_q    <= req_op_in;
         byte_q  <= req_byte_in;
         addr_q  <= req_addr_in;
         wdata_q <= req_wdata_in;
         dest_q  <= req_dest_in;
      end
   end

   // wait counter, abort/suppress marks and the sticky timeout flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         aborted   <= 1'b0;
         suppress  <= 1'b0;
         timeout_q <= 1'b0;
      end else if (accept) begin
         cnt      <= '0;
         aborted  <= 1'b0;
         suppress <= 1'b0;
      end else if (state == WAIT) begin
         cnt <= cnt + 1'b1;
         if (flush_in) suppress <= 1'b1;
         if (expire) begin
            aborted   <= 1'b1;
            timeout_q <= 1'b1;
         end
      end
   end

   // writeback registers only move when a load is actually written back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_dest_q <= '0;
         wb_data_q <= '0;
      end else if (wb_take) begin
         wb_dest_q <= dest_q;
         wb_data_q <= byte_q ? {{(WORD_WIDTH-8){1'b0}}, rbyte} : cache_rdata_in;
      end
   end

   assign cache_req_out   = (state == WAIT);
   assign cache_op_out    = op_q;
   assign cache_byte_out  = byte_q;
   assign cache_addr_out  = addr_q;
   assign cache_wdata_out = wdata_q;
   assign stall_out       = (state == WAIT) || (state == DONE);
   assign busy_out        = (state != IDLE);
   assign unlock_out      = (state == DONE);
   assign wb_valid_out    = (state == DONE) && !op_q && !aborted && !suppress;
   assign wb_dest_out     = wb_dest_q;
   assign wb_data_out     = wb_data_q;
   assign timeout_out     = timeout_q;

endmodule

// File: tb/tb_dcache_access_controller.sv
// Bench for dcache_access_controller: a transaction-level model predicts
// every output each cycle, directed transactions pin the model with
// hand-computed values, then randomized traffic runs against the model.
module tb_dcache_access_controller;

   localparam int W  = 32;
   localparam int RW = 5;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0, req_op = 1'b0, req_byte = 1'b0;
   logic [W-1:0]  req_addr = '0, req_wdata = '0;
   logic [RW-1:0] req_dest = '0;
   logic          flush = 1'b0, cache_ready = 1'b0;
   logic [W-1:0]  cache_rdata = '0;

   logic          cache_req_out, cache_op_out, cache_byte_out;
   logic [W-1:0]  cache_addr_out, cache_wdata_out;
   logic          stall_out, unlock_out, wb_valid_out;
   logic [RW-1:0] wb_dest_out;
   logic [W-1:0]  wb_data_out;
   logic          timeout_out, busy_out;

   int cmp_cnt = 0;
   int err_cnt = 0;

   dcache_access_controller #(.WORD_WIDTH(W), .REGISTER_INDEX_WIDTH(RW),
                              .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(7)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_in(req_valid), .req_op_in(req_op), .req_byte_in(req_byte),
      .req_addr_in(req_addr), .req_wdata_in(req_wdata), .req_dest_in(req_dest),
      .flush_in(flush), .cache_ready_in(cache_ready), .cache_rdata_in(cache_rdata),
      .cache_req_out(cache_req_out), .cache_op_out(cache_op_out),
      .cache_byte_out(cache_byte_out), .cache_addr_out(cache_addr_out),
      .cache_wdata_out(cache_wdata_out), .stall_out(stall_out),
      .unlock_out(unlock_out), .wb_valid_out(wb_valid_out),
      .wb_dest_out(wb_dest_out), .wb_data_out(wb_data_out),
      .timeout_out(timeout_out), .busy_out(busy_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // m_phase: 0 no access, 1 access outstanding at the cache, 2 completion cycle
   int            m_phase = 0;
   int            m_waits = 0;
   logic          m_op = 0, m_byte = 0, m_abort = 0, m_supp = 0, m_to = 0;
   logic [W-1:0]  m_addr = '0, m_wdata = '0, m_wb_data = '0;
   logic [RW-1:0] m_dest = '0, m_wb_dest = '0;

   function automatic logic [W-1:0] load_result(input logic byt, input logic [W-1:0] addr,
                                                input logic [W-1:0] rdata);
      int sh;
      sh = 8 * int'(addr % 4);
      return byt ? ((rdata >> sh) & 32'hFF) : rdata;
   endfunction

   // model update at every edge the DUT samples
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0; m_waits <= 0; m_op <= 0; m_byte <= 0; m_abort <= 0;
         m_supp <= 0; m_to <= 0; m_addr <= '0; m_wdata <= '0; m_dest <= '0;
         m_wb_data <= '0; m_wb_dest <= '0;
      end else begin
         if (m_phase == 0) begin
            if (req_valid && !flush) begin
               m_phase <= 1; m_waits <= 0; m_abort <= 0; m_supp <= 0;
               m_op <= req_op; m_byte <= req_byte; m_addr <= req_addr;
               m_wdata <= req_wdata; m_dest <= req_dest;
            end
         end else if (m_phase == 1) begin
            m_waits <= m_waits + 1;
            if (flush) m_supp <= 1;
            if (cache_ready) begin
               m_phase <= 2;
               if (!m_op && !m_supp && !flush) begin
                  m_wb_dest <= m_dest;
                  m_wb_data <= load_result(m_byte, m_addr, cache_rdata);
               end
            end else if (m_waits + 1 == TO) begin
               m_phase <= 2; m_abort <= 1; m_to <= 1;
            end
         end else begin
            m_phase <= 0;
         end
      end
   end

   // compare process: every output, every cycle, away from the active edge
   always @(negedge clk) begin
      check("busy",      busy_out,        m_phase != 0);
      check("stall",     stall_out,       m_phase != 0);
      check("cache_req", cache_req_out,   m_phase == 1);
      check("unlock",    unlock_out,      m_phase == 2);
      check("wb_valid",  wb_valid_out,    (m_phase == 2) && !m_op && !m_abort && !m_supp);
      check("cache_op",  cache_op_out,    m_op);
      check("cache_byte",cache_byte_out,  m_byte);
      check("cache_addr",cache_addr_out,  m_addr);
      check("cache_wdata",cache_wdata_out,m_wdata);
      check("wb_dest",   wb_dest_out,     m_wb_dest);
      check("wb_data",   wb_data_out,     m_wb_data);
      check("timeout",   timeout_out,     m_to);
   end

   // ---------------- directed transaction driver ----------------
   int           t_stall, t_unlock, t_wbv, t_bad, t_creq;
   logic [W-1:0] t_data;
   logic [RW-1:0] t_dest;

   // d = edge index (after accept) carrying ready, 0 = never; f = flush edge, 0 = none
   task automatic run_txn(input logic op, input logic byt, input logic [W-1:0] addr,
                          input logic [W-1:0] wdata, input logic [RW-1:0] dest,
                          input int d, input logic [W-1:0] rdata, input int f);
      bit done;
      t_stall = 0; t_unlock = 0; t_wbv = 0; t_bad = 0; t_creq = 0; t_data = '0; t_dest = '0;
      @(negedge clk);
      req_valid = 1; req_op = op; req_byte = byt; req_addr = addr;
      req_wdata = wdata; req_dest = dest; cache_rdata = rdata;
      cache_ready = 0; flush = 0;
      done = 0;
      for (int k = 1; k <= 150 && !done; k++) begin
         @(negedge clk);
         if (stall_out) t_stall++;
         if (cache_req_out) begin
            t_creq++;
            if (cache_addr_out !== addr || cache_wdata_out !== wdata || cache_op_out !== op)
               t_bad++;
         end
         if (unlock_out) t_unlock++;
         if (wb_valid_out) begin t_wbv++; t_data = wb_data_out; t_dest = wb_dest_out; end
         if (t_unlock > 0 && !unlock_out) done = 1;
         req_valid = 0;
         cache_ready = (k == d);
         flush = (k == f);
      end
      cache_ready = 0; flush = 0;
      if (!done) check("txn_budget", 0, 1);
   endtask

   initial begin
      // reset state
      #12;
      check("rst_req",     cache_req_out, 0);
      check("rst_stall",   stall_out, 0);
      check("rst_timeout", timeout_out, 0);
      check("rst_wb_data", wb_data_out, 0);
      @(negedge clk); rst_n = 1;
      repeat (2) @(negedge clk);

      // word load, ready at the second edge after accept
      run_txn(0, 0, 32'h10, 32'h0, 5'd5, 2, 32'hDEADBEEF, 0);
      check("wl_stall",  t_stall, 3);
      check("wl_unlock", t_unlock, 1);
      check("wl_wbv",    t_wbv, 1);
      check("wl_dest",   t_dest, 5);
      check("wl_data",   t_data, 32'hDEADBEEF);

      // byte load from lane 3
      run_txn(0, 1, 32'h13, 32'h0, 5'd9, 1, 32'hAABBCCDD, 0);
      check("bl_data", t_data, 32'h000000AA);
      check("bl_hold", wb_data_out, 32'h000000AA);

      // store, ready on the first edge
      run_txn(1, 0, 32'h20, 32'h12345678, 5'd3, 1, 32'hFFFFFFFF, 0);
      check("st_held",   t_bad, 0);
      check("st_creq",   t_creq, 1);
      check("st_unlock", t_unlock, 1);
      check("st_wbv",    t_wbv, 0);
      check("st_wdata",  cache_wdata_out, 32'h12345678);
      check("st_wb_keep",wb_data_out, 32'h000000AA);

      // load flushed while waiting: access completes, no writeback
      run_txn(0, 0, 32'h44, 32'h0, 5'd7, 4, 32'h01020304, 2);
      check("fl_creq",   t_creq, 4);
      check("fl_unlock", t_unlock, 1);
      check("fl_wbv",    t_wbv, 0);

      // ready exactly on the timeout cycle wins
      run_txn(0, 0, 32'h50, 32'h0, 5'd11, TO, 32'hCAFEF00D, 0);
      check("rw_timeout", timeout_out, 0);
      check("rw_wbv",     t_wbv, 1);
      check("rw_data",    t_data, 32'hCAFEF00D);

      // no ready at all: abort after 64 waiting cycles
      run_txn(0, 0, 32'h60, 32'h0, 5'd12, 0, 32'h0, 0);
      check("to_stall",   t_stall, TO + 1);
      check("to_flag",    timeout_out, 1);
      check("to_unlock",  t_unlock, 1);
      check("to_wbv",     t_wbv, 0);
      check("to_wb_keep", wb_data_out, 32'hCAFEF00D);

      // reset in the middle of a waiting access
      @(negedge clk);
      req_valid = 1; req_op = 0; req_byte = 0; req_addr = 32'h70; req_dest = 5'd2;
      @(negedge clk); req_valid = 0;
      check("mr_busy_before", busy_out, 1);
      #2 rst_n = 0;
      #1;
      check("mr_req",     cache_req_out, 0);
      check("mr_stall",   stall_out, 0);
      check("mr_addr",    cache_addr_out, 0);
      check("mr_timeout", timeout_out, 0);
      check("mr_wb_data", wb_data_out, 0);
      @(negedge clk); rst_n = 1;
      t_unlock = 0;
      repeat (4) begin
         @(negedge clk);
         if (unlock_out || wb_valid_out) t_unlock++;
      end
      check("mr_no_unlock", t_unlock, 0);
      run_txn(0, 0, 32'h80, 32'h0, 5'd4, 3, 32'h55AA55AA, 0);
      check("mr_new_wbv",  t_wbv, 1);
      check("mr_new_data", t_data, 32'h55AA55AA);

      // randomized traffic against the model
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         req_valid   = ($urandom_range(0, 3) != 0);
         req_op      = $urandom_range(0, 1);
         req_byte    = $urandom_range(0, 1);
         req_addr    = $urandom;
         req_wdata   = $urandom;
         req_dest    = RW'($urandom);
         flush       = ($urandom_range(0, 7) == 0);
         cache_ready = ($urandom_range(0, 2) == 0);
         cache_rdata = $urandom;
      end
      @(negedge clk);
      req_valid = 0; flush = 0; cache_ready = 1;
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
